// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_pkg
//  Description : Shared types and helpers for the binarised-neuron popcount
//                accumulator. The typedefs describe the default 64-bit beat,
//                16-bit accumulator configuration. The helpers are written so
//                they can be reused at any width.
//  Contents    : DEF_* width constants, word_t / nbits_t / acc_t typedefs,
//                popcount() reference function, nbits_mask() lane helper
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package popcount_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_NB_W   = $clog2(DEF_DATA_W + 1);

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_NB_W-1:0]   nbits_t;
    typedef logic [DEF_ACC_W-1:0]  acc_t;

    // Behavioural popcount of a default-width word.
    function automatic nbits_t popcount(input word_t word);
        nbits_t cnt;
        cnt = '0;
        for (int i = 0; i < DEF_DATA_W; i++) begin
            cnt = cnt + nbits_t'(word[i]);
        end
        return cnt;
    endfunction

    // Lane idx is kept when it lies below the beat's valid bit count.
    // Evaluated per lane, so one helper serves every DATA_W.
    function automatic logic nbits_mask(input int idx, input int nbits);
        return (idx < nbits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_tree.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_tree
//  Description : Combinational popcount, built as a balanced binary adder tree
//                in heap order. Leaves are the input bits. Node i sums nodes
//                2i and 2i+1, and node 1 is the root.
//  Ports       : word  [DATA_W-1:0] in  - bits to count
//                count [NB_W-1:0]   out - number of ones in word
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module popcount_tree #(
    parameter  int DATA_W = 64,
    localparam int NB_W   = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] word,
    output logic [NB_W-1:0]   count
);

    // Every node uses the full result width. The root can reach DATA_W,
    // which NB_W holds by construction. DATA_W must be a power of two.
    logic [NB_W-1:0] w_node [2*DATA_W];

    always_comb begin
        for (int i = 0; i < 2 * DATA_W; i++) begin
            w_node[i] = '0;
        end
        for (int i = 0; i < DATA_W; i++) begin
            w_node[DATA_W + i] = NB_W'(word[i]);
        end
        for (int i = DATA_W - 1; i >= 1; i--) begin
            w_node[i] = w_node[2*i] + w_node[2*i + 1];
        end
    end

    assign count = w_node[1];

endmodule
`default_nettype wire

// File: rtl/popcount_acc.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_acc
//  Description : Multi-beat binarised-neuron accumulator. Each accepted beat is
//                optionally XNORed with the weights, masked to its valid bit
//                count and popcounted. Counts are summed until s_last. At that
//                point the frame result 2*pcnt - n_total is emitted with an
//                overflow flag.
//                Pipeline: P1 mask -> P2 popcount -> P3 accumulate -> output.
//                A single global enable freezes every stage under
//                backpressure.
//  Ports       : clk, rst (async, active-low)
//                s_valid/s_ready/s_data/s_weight/s_nbits/s_last - beat input
//                m_valid/m_ready/m_data/m_pcnt/m_ovf            - frame result
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module popcount_acc
    import popcount_pkg::*;
#(
    parameter  int DATA_W  = 64,
    parameter  int ACC_W   = 16,
    parameter  int XNOR_EN = 1,
    localparam int NB_W    = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [DATA_W-1:0] s_weight,
    input  logic [NB_W-1:0]   s_nbits,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_data,
    output logic [ACC_W-1:0]  m_pcnt,
    output logic              m_ovf
);

    // Largest bit total whose signed result still fits in ACC_W bits.
    localparam logic [ACC_W:0] c_n_limit = (ACC_W+1)'((1 << (ACC_W - 1)) - 1);

    logic              w_en;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_word_m;
    logic [NB_W-1:0]   w_nbits_c;
    logic [NB_W-1:0]   w_pc;
    logic [ACC_W:0]    w_sum_pc;
    logic [ACC_W:0]    w_sum_n;
    logic              w_exceed;
    logic [ACC_W-1:0]  w_res;

    // P1 registers
    logic              r1_valid;
    logic [DATA_W-1:0] r1_word;
    logic [NB_W-1:0]   r1_nbits;
    logic              r1_last;
    // P2 registers
    logic              r2_valid;
    logic [NB_W-1:0]   r2_pc;
    logic [NB_W-1:0]   r2_nbits;
    logic              r2_last;
    // P3 accumulators and finished-frame registers
    logic [ACC_W:0]    r_acc_pc;
    logic [ACC_W:0]    r_acc_n;
    logic              r_ovf_sticky;
    logic              r3_valid;
    logic [ACC_W-1:0]  r3_pc;
    logic [ACC_W-1:0]  r3_n;
    logic              r3_ovf;

    // The pipeline moves whenever the output slot is free or is being
    // drained this cycle. Inputs are refused while reset is asserted.
    assign w_en    = !m_valid || m_ready;
    assign s_ready = w_en && rst;

    if (XNOR_EN != 0) begin : g_xnor
        assign w_word = ~(s_data ^ s_weight);
    end else begin : g_plain
        logic w_unused_weight;
        assign w_word          = s_data;
        assign w_unused_weight = ^s_weight;
    end

    // Counts above DATA_W are clamped, so a beat never claims more lanes
    // than it carries.
    assign w_nbits_c = (s_nbits > NB_W'(DATA_W)) ? NB_W'(DATA_W) : s_nbits;

    always_comb begin
        w_word_m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_word_m[i] = w_word[i] & nbits_mask(i, int'(w_nbits_c));
        end
    end

    popcount_tree #(
        .DATA_W (DATA_W)
    ) u_tree (
        .word  (r1_word),
        .count (w_pc)
    );

    // The accumulators carry one extra bit so that overflow detection sees
    // the true total of a frame that crosses the signed limit.
    assign w_sum_pc = r_acc_pc + (ACC_W+1)'(r2_pc);
    assign w_sum_n  = r_acc_n  + (ACC_W+1)'(r2_nbits);
    assign w_exceed = (w_sum_n > c_n_limit);

    // 2*pcnt - n_total, truncated to ACC_W bits.
    assign w_res = {r3_pc[ACC_W-2:0], 1'b0} - r3_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_valid     <= 1'b0;
            r1_word      <= '0;
            r1_nbits     <= '0;
            r1_last      <= 1'b0;
            r2_valid     <= 1'b0;
            r2_pc        <= '0;
            r2_nbits     <= '0;
            r2_last      <= 1'b0;
            r_acc_pc     <= '0;
            r_acc_n      <= '0;
            r_ovf_sticky <= 1'b0;
            r3_valid     <= 1'b0;
            r3_pc        <= '0;
            r3_n         <= '0;
            r3_ovf       <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_pcnt       <= '0;
            m_ovf        <= 1'b0;
        end else if (w_en) begin
            // P1: capture the masked beat. With rst high, s_ready equals
            // w_en, so s_valid alone marks an accept here.
            r1_valid <= s_valid;
            if (s_valid) begin
                r1_word  <= w_word_m;
                r1_nbits <= w_nbits_c;
                r1_last  <= s_last;
            end

            // P2: register the popcount.
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_pc    <= w_pc;
                r2_nbits <= r1_nbits;
                r2_last  <= r1_last;
            end

            // P3: accumulate. The last beat hands the frame off and
            // restarts the accumulators, so the next frame follows with no
            // gap.
            r3_valid <= r2_valid && r2_last;
            if (r2_valid) begin
                if (r2_last) begin
                    r3_pc        <= w_sum_pc[ACC_W-1:0];
                    r3_n         <= w_sum_n[ACC_W-1:0];
                    r3_ovf       <= r_ovf_sticky || w_exceed;
                    r_acc_pc     <= '0;
                    r_acc_n      <= '0;
                    r_ovf_sticky <= 1'b0;
                end else begin
                    r_acc_pc     <= w_sum_pc;
                    r_acc_n      <= w_sum_n;
                    r_ovf_sticky <= r_ovf_sticky || w_exceed;
                end
            end

            // Output: a new result replaces the held one in the same cycle
            // that it drains. Data holds while no result is pending.
            m_valid <= r3_valid;
            if (r3_valid) begin
                m_pcnt <= r3_pc;
                m_data <= w_res;
                m_ovf  <= r3_ovf;
            end
        end
    end

endmodule
`default_nettype wire
